// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and error check for the data-memory responder
package dmem_responder_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        mem_op_t op;
        u32_t    addr;
        u32_t    wdata;
        wrstb_t  wrstb;
    } dmem_req_t;

    // Misaligned, out-of-range, or a store strobe that is not a naturally
    // aligned byte, halfword or word.
    function automatic logic req_err(input dmem_req_t r, input int unsigned depth_words);
        logic bad_strb;
        case (r.wrstb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: bad_strb = 1'b0;
            default:                   bad_strb = 1'b1;
        endcase
        return (r.addr[1:0] != 2'b00)
            || (r.addr >= 32'(depth_words * 4))
            || ((r.op == STORE) && bad_strb);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port byte-strobed word array with registered read
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] idx,
    input  wrstb_t        wrstb,
    input  u32_t          wdata,
    output u32_t          rdata
);

    u32_t mem [DEPTH_WORDS];
    u32_t rdata_d;
    u32_t rdata_q;

    // Read data only updates on an access so it holds for the whole response.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[idx];
        end
    end

    // Byte-lane write and read capture on the same edge.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wrstb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - request/response data-memory responder (optional DMEM_RESPONDER_ERR_EN error reporting)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req_valid,
    output logic    req_ready,
    input  mem_op_t req_op,
    input  u32_t    req_addr,
    input  u32_t    req_wdata,
    input  wrstb_t  req_wrstb,
    output logic    rsp_valid,
    input  logic    rsp_ready,
    output u32_t    rsp_rdata,
    output logic    rsp_is_store
`ifdef DMEM_RESPONDER_ERR_EN
    ,
    output logic    rsp_err
`endif
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    dmem_req_t   req_d, req_q;
    logic        ram_en;
    wrstb_t      ram_wrstb;
    u32_t        ram_rdata;
    logic        err_next;
    logic        err_cur;

`ifdef DMEM_RESPONDER_ERR_EN
    assign err_next = req_err(req_d, DEPTH_WORDS);
    assign err_cur  = req_err(req_q, DEPTH_WORDS);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_q.addr[31:AW+2], req_q.addr[1:0], req_d.addr[31:AW+2], req_d.addr[1:0]};
    assign err_next = 1'b0;
    assign err_cur  = 1'b0;
`endif

    // Next-state, counter and request latch; the RAM access fires on the edge entering RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        ram_en    = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_op == LOAD || req_op == STORE)) begin
                    req_d.op    = req_op;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.wrstb = req_wrstb;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        ram_en  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ram_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Erroring stores and loads never commit a write.
    always_comb begin
        ram_wrstb = '0;
        if (req_d.op == STORE && !err_next) begin
            ram_wrstb = req_d.wrstb;
        end
    end

    // State register; reset drops any pending transaction but leaves memory alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en && !rst),
        .idx   (req_d.addr[AW+1:2]),
        .wrstb (ram_wrstb),
        .wdata (req_d.wdata),
        .rdata (ram_rdata)
    );

    // Response outputs are forced to zero outside RESP.
    always_comb begin
        rsp_valid    = (state_q == RESP);
        rsp_is_store = (state_q == RESP) && (req_q.op == STORE);
        rsp_rdata    = '0;
        if (state_q == RESP && req_q.op == LOAD && !err_cur) begin
            rsp_rdata = ram_rdata;
        end
    end

`ifdef DMEM_RESPONDER_ERR_EN
    assign rsp_err = (state_q == RESP) && err_cur;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    import dmem_responder_pkg::*;

`ifdef DMEM_RESPONDER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      n_chk = 0;
    int      n_fail = 0;

    logic    req_valid = 1'b0;
    logic    req_ready;
    mem_op_t req_op = NONE;
    u32_t    req_addr = '0;
    u32_t    req_wdata = '0;
    wrstb_t  req_wrstb = '0;
    logic    rsp_valid;
    logic    rsp_ready = 1'b0;
    u32_t    rsp_rdata;
    logic    rsp_is_store;

    logic    req_valid_b = 1'b0;
    logic    req_ready_b;
    mem_op_t req_op_b = NONE;
    u32_t    req_addr_b = '0;
    u32_t    req_wdata_b = '0;
    wrstb_t  req_wrstb_b = '0;
    logic    rsp_valid_b;
    logic    rsp_ready_b = 1'b1;
    u32_t    rsp_rdata_b;
    logic    rsp_is_store_b;

`ifdef DMEM_RESPONDER_ERR_EN
    logic    rsp_err;
    logic    rsp_err_b;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wrstb(req_wrstb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_is_store(rsp_is_store)
`ifdef DMEM_RESPONDER_ERR_EN
        , .rsp_err(rsp_err)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wrstb(req_wrstb_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        .rsp_is_store(rsp_is_store_b)
`ifdef DMEM_RESPONDER_ERR_EN
        , .rsp_err(rsp_err_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=1 instance with exact latency checks.
    task automatic xact(input string tag, input mem_op_t op, input u32_t addr, input u32_t wdata,
                        input wrstb_t strb, input u32_t exp_rdata, input logic exp_err);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_wrstb = strb;
        rsp_ready = 1'b1;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_is_store"}, 32'(rsp_is_store), 32'(op == STORE));
`ifdef DMEM_RESPONDER_ERR_EN
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
`else
        chk({tag, "_err_unused"}, 32'(exp_err), 32'(rsp_valid & 1'b0));
`endif
        step();
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_done_store"}, 32'(rsp_is_store), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_store", 32'(rsp_is_store), 32'd0);
        chk("rst_valid_b", 32'(rsp_valid_b), 32'd0);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ready_b", 32'(req_ready_b), 32'd1);

        // Full-word store and readback
        xact("st10", STORE, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xact("ld10", LOAD, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Partial store merges into the existing word
        xact("st20", STORE, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xact("st20b", STORE, 32'h20, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        xact("ld20", LOAD, 32'h20, 32'h0, 4'h0, 32'h112233AA, 1'b0);
        xact("st20h", STORE, 32'h20, 32'h5566_0000, 4'b1100, 32'h0, 1'b0);
        xact("ld20h", LOAD, 32'h20, 32'h0, 4'h0, 32'h556633AA, 1'b0);

        // Zero strobe writes nothing but still responds
        xact("st20z", STORE, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, ERR);
        xact("ld20z", LOAD, 32'h20, 32'h0, 4'h0, 32'h556633AA, 1'b0);

        // Low address bits ignored and high bits alias (errors when checking is built in)
        xact("ld13", LOAD, 32'h13, 32'h0, 4'h0, ERR ? 32'h0 : 32'hDEADBEEF, ERR);
        xact("ld1010", LOAD, 32'h1010, 32'h0, 4'h0, ERR ? 32'h0 : 32'hDEADBEEF, ERR);

        // Backpressure: response holds while rsp_ready is low
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = LOAD;
        req_addr  = 32'h10;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'd0);
            step();
        end
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);

        // NONE and reserved encodings are consumed silently
        req_valid = 1'b1;
        req_op    = NONE;
        step();
        chk("none_valid", 32'(rsp_valid), 32'd0);
        chk("none_ready", 32'(req_ready), 32'd1);
        req_op = mem_op_t'(2'b11);
        step();
        chk("op3_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("op3_valid2", 32'(rsp_valid), 32'd0);
        chk("op3_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        req_op    = NONE;

        // Reset during WAIT drops the load; memory survives
        xact("st0", STORE, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_op    = LOAD;
        req_addr  = 32'h0;
        step();
        req_valid = 1'b0;
        chk("rstw_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        step();
        chk("rstw_valid2", 32'(rsp_valid), 32'd0);
        xact("ld0", LOAD, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);

`ifdef DMEM_RESPONDER_ERR_EN
        xact("err_ld3", LOAD, 32'h3, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("err_st_oor", STORE, 32'd4096, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        xact("err_st_strb", STORE, 32'h0, 32'hFFFFFFFF, 4'b0110, 32'h0, 1'b1);
        xact("err_ld0", LOAD, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);
`endif

        // Zero-wait instance: back-to-back stores then loads, one every 2 cycles
        req_valid_b = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                req_op_b    = (pass == 0) ? STORE : LOAD;
                req_addr_b  = 32'h4 * (i + 1);
                req_wdata_b = 32'hA0 + i;
                req_wrstb_b = 4'hF;
                chk($sformatf("b2b_ready_%0d_%0d", pass, i), 32'(req_ready_b), 32'd1);
                step();
                chk($sformatf("b2b_valid_%0d_%0d", pass, i), 32'(rsp_valid_b), 32'd1);
                chk($sformatf("b2b_busy_%0d_%0d", pass, i), 32'(req_ready_b), 32'd0);
                chk($sformatf("b2b_store_%0d_%0d", pass, i), 32'(rsp_is_store_b), 32'(pass == 0));
                chk($sformatf("b2b_rdata_%0d_%0d", pass, i), rsp_rdata_b, (pass == 0) ? 32'h0 : 32'hA0 + i);
                step();
                chk($sformatf("b2b_idle_%0d_%0d", pass, i), 32'(rsp_valid_b), 32'd0);
            end
        end
        req_op_b = NONE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("b_none_valid_%0d", i), 32'(rsp_valid_b), 32'd0);
            chk($sformatf("b_none_ready_%0d", i), 32'(req_ready_b), 32'd1);
        end
        req_valid_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; SHALL be a power of two and at least 2.
REQ-002 Parameter WAIT_CYCLES, default 1, number of extra cycles before a response; SHALL be in the range 0..15.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset; reset is sampled only on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_op  input  2  mem_op_t: NONE, LOAD or STORE.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wrstb  input  4  wrstb_t byte-lane write enables.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts the response.
REQ-014 rsp_rdata  output  32  load data; 0 for a store.
REQ-015 rsp_is_store  output  1  the response belongs to a store.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-019 An accepted request with NONE, or with the encoding 2'b11, SHALL be consumed with no state change and no response.
REQ-020 An accepted LOAD or STORE SHALL latch op, addr, wdata and wrstb.
REQ-021 On an accepted LOAD or STORE the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES is 0.
REQ-022 In WAIT the counter SHALL decrement once per cycle; the FSM SHALL go to RESP on the cycle after the counter reads 0.
REQ-023 The memory access SHALL be performed on the edge entering RESP, so rsp_valid first rises WAIT_CYCLES+1 cycles after acceptance.
REQ-024 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored; higher address bits SHALL alias.
REQ-025 For a STORE, byte lane i (bits 8i+7:8i) SHALL be written only when wrstb[i] is 1.
REQ-026 A STORE with wrstb of 0 SHALL write nothing but SHALL still respond.
REQ-027 For a LOAD, rsp_rdata SHALL be the full stored word; lane selection and sign extension are the requester's job.
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_is_store SHALL hold stable until rsp_ready is 1.
REQ-029 On the rsp_valid and rsp_ready handshake the FSM SHALL go to IDLE; the next request is accepted one cycle later, at the earliest.
REQ-030 A LOAD issued after a STORE to the same word SHALL return the post-store data.
REQ-031 Outside RESP, rsp_rdata and rsp_is_store SHALL be 0.

Reset
REQ-032 On reset the FSM SHALL enter IDLE, the counter SHALL be 0, and rsp_valid, rsp_rdata and rsp_is_store SHALL be 0; req_ready SHALL be 1 from the first cycle after reset.
REQ-033 Reset in WAIT or RESP SHALL drop the pending transaction without a response.
REQ-034 Reset SHALL NOT clear memory contents; a store already committed on entry to RESP SHALL persist.

Configuration
REQ-035 With DMEM_RESPONDER_ERR_EN defined, the module SHALL add output rsp_err (1 bit), asserted together with rsp_valid.
REQ-036 Under DMEM_RESPONDER_ERR_EN, an error occurs when addr[1:0] is not 0, or addr is at least DEPTH_WORDS*4, or the STORE strobe is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-037 An erroring STORE SHALL write nothing; an erroring LOAD SHALL return 0.
REQ-038 Without DMEM_RESPONDER_ERR_EN, the rsp_err port and all checks SHALL be absent and REQ-024 aliasing SHALL apply.

Structure
REQ-039 Package types SHALL add dmem_state_t (IDLE, WAIT, RESP) and struct dmem_req_t (op, addr, wdata, wrstb); it SHALL reuse u32_t, wrstb_t and mem_op_t.
REQ-040 Sub-module dmem_ram SHALL hold the single-port, byte-strobed word array with a synchronous write; the FSM, counter and error logic SHALL stay in dmem_responder.

Verification
REQ-041 WAIT_CYCLES=1: STORE 0xDEADBEEF to 0x10 with wrstb 1111, then LOAD 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid 2 cycles after each acceptance.
REQ-042 Partial store: word at 0x20 = 0x11223344, STORE 0x000000AA with wrstb 0001, then LOAD 0x20 -> 0x112233AA.
REQ-043 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready 0 throughout; IDLE after the handshake.
REQ-044 WAIT_CYCLES=0: back-to-back requests -> one accepted every 2 cycles with rsp_ready tied 1; NONE op -> no rsp_valid.
REQ-045 Reset during WAIT of a LOAD -> no rsp_valid; earlier stored 0x12345678 at 0x0 still reads back 0x12345678.
REQ-046 With DMEM_RESPONDER_ERR_EN: LOAD 0x3 -> rsp_err 1, rdata 0; STORE to DEPTH_WORDS*4 -> rsp_err 1 and word 0 unchanged.
